// File: rtl/matrix_scanner.sv
// Row-scanning driver for bi-colour LED matrices with blanking, bank select and frame sync.
// Define MATRIX_SCAN_PWM_EN to build per-row BRIGHT-based PWM gating of the column outputs.
module matrix_scanner #(
    parameter int unsigned         ROWS      = 8,
    parameter int unsigned         COLS      = 8,
    parameter int unsigned         ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]   FB_BASE   = 12'hF00,
    parameter int unsigned         ROW_CYC   = 4096,
    parameter int unsigned         BLANK_CYC = 16,
    parameter int unsigned         PWM_BITS  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                BANK,
    input  logic [PWM_BITS-1:0] BRIGHT,
    input  logic [2*COLS-1:0]   RAM_Q,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic [COLS-1:0]     L_GREEN,
    output logic [COLS-1:0]     L_RED,
    output logic [ROWS-1:0]     L_VCC,
    output logic                FRAME
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned C_W   = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [C_W-1:0]   C_LAST   = C_W'(ROW_CYC - 1);
    localparam logic [C_W-1:0]   C_CAP    = C_W'(BLANK_CYC - 1);
    localparam logic [C_W-1:0]   C_SHOW   = C_W'(BLANK_CYC);

    typedef enum logic {
        ST_SCAN,
        ST_IDLE
    } state_t;

    state_t             r_state, w_state_nx;
    logic [C_W-1:0]     r_c, w_c_nx;
    logic [ROW_W-1:0]   r_row, w_row_nx;
    logic               r_bank, w_bank_nx;
    logic [2*COLS-1:0]  r_data, w_data_nx;
    logic [ADDR_W-1:0]  r_addr, w_addr_nx;
    logic [ROWS-1:0]    r_vcc, w_vcc_nx;
    logic [COLS-1:0]    r_red, w_red_nx;
    logic [COLS-1:0]    r_green, w_green_nx;
    logic               r_frame, w_frame_nx;
    logic               w_capture;
    logic               w_show;
    logic               w_pwm_on;

`ifdef MATRIX_SCAN_PWM_EN
    logic [PWM_BITS-1:0] r_bright, w_bright_nx;
    logic [PWM_BITS-1:0] r_pwm, w_pwm_nx;
`else
    logic                w_unused_bright;
    assign w_unused_bright = ^BRIGHT;
`endif

    // Outputs are computed from the next-cycle counters so each registered
    // output lines up with the counter value it belongs to.
    always_comb begin
        w_state_nx = r_state;
        w_c_nx     = r_c;
        w_row_nx   = r_row;
        w_bank_nx  = r_bank;
        w_frame_nx = 1'b0;
        w_capture  = 1'b0;

        if (!EN) begin
            w_state_nx = ST_IDLE;
            w_c_nx     = '0;
            w_row_nx   = '0;
        end else if (r_state == ST_IDLE) begin
            w_state_nx = ST_SCAN;
            w_c_nx     = '0;
            w_row_nx   = '0;
            w_bank_nx  = BANK;
        end else begin
            w_capture = (r_c == C_CAP);
            if (r_c == C_LAST) begin
                w_c_nx = '0;
                if (r_row == ROW_LAST) begin
                    w_row_nx   = '0;
                    w_bank_nx  = BANK;
                    w_frame_nx = 1'b1;
                end else begin
                    w_row_nx = r_row + 1'b1;
                end
            end else begin
                w_c_nx = r_c + 1'b1;
            end
        end

        w_data_nx = w_capture ? RAM_Q : r_data;
        w_show    = (w_state_nx == ST_SCAN) && (w_c_nx >= C_SHOW);

`ifdef MATRIX_SCAN_PWM_EN
        // The PWM phase restarts at the first SHOW cycle, so it equals k mod 2^PWM_BITS.
        w_bright_nx = w_capture ? BRIGHT : r_bright;
        w_pwm_nx    = w_capture ? '0 : r_pwm + 1'b1;
        w_pwm_on    = (w_pwm_nx < w_bright_nx) || (&w_bright_nx);
`else
        w_pwm_on    = 1'b1;
`endif

        if (w_state_nx == ST_SCAN) begin
            w_addr_nx = FB_BASE + (w_bank_nx ? ADDR_W'(ROWS) : '0) + ADDR_W'(w_row_nx);
        end else begin
            w_addr_nx = FB_BASE;
        end

        w_vcc_nx   = w_show ? (ROWS'(1) << w_row_nx) : '0;
        w_red_nx   = (w_show && w_pwm_on) ? ~w_data_nx[2*COLS-1:COLS] : '1;
        w_green_nx = (w_show && w_pwm_on) ? ~w_data_nx[COLS-1:0]      : '1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_SCAN;
            r_c      <= '0;
            r_row    <= '0;
            r_bank   <= 1'b0;
            r_data   <= '0;
            r_addr   <= FB_BASE;
            r_vcc    <= '0;
            r_red    <= '1;
            r_green  <= '1;
            r_frame  <= 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
            r_bright <= '0;
            r_pwm    <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_c      <= w_c_nx;
            r_row    <= w_row_nx;
            r_bank   <= w_bank_nx;
            r_data   <= w_data_nx;
            r_addr   <= w_addr_nx;
            r_vcc    <= w_vcc_nx;
            r_red    <= w_red_nx;
            r_green  <= w_green_nx;
            r_frame  <= w_frame_nx;
`ifdef MATRIX_SCAN_PWM_EN
            r_bright <= w_bright_nx;
            r_pwm    <= w_pwm_nx;
`endif
        end
    end

    assign RAM_ADDR = r_addr;
    assign L_VCC    = r_vcc;
    assign L_RED    = r_red;
    assign L_GREEN  = r_green;
    assign FRAME    = r_frame;

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: per-cycle scoreboard from a behavioural model plus directed checks.
module tb_matrix_scanner;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int ROW_CYC   = 64;
    localparam int BLANK_CYC = 4;
    localparam int PWM_BITS  = 4;
    localparam logic [11:0] BASE = 12'hF00;
`ifdef MATRIX_SCAN_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        clk_run = 1'b1;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b1;
    logic        bank    = 1'b0;
    logic [3:0]  bright  = 4'hF;
    logic [15:0] ram_q   = '0;
    logic [11:0] ram_addr;
    logic [7:0]  l_green, l_red, l_vcc;
    logic        frame;

    always #5 if (clk_run) clk = ~clk;

    always @(posedge clk) ram_q <= {ram_addr[7:0], ~ram_addr[7:0]};

    matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(12), .FB_BASE(12'hF00),
        .ROW_CYC(ROW_CYC), .BLANK_CYC(BLANK_CYC), .PWM_BITS(PWM_BITS)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .BANK(bank), .BRIGHT(bright),
        .RAM_Q(ram_q), .RAM_ADDR(ram_addr), .L_GREEN(l_green), .L_RED(l_red),
        .L_VCC(l_vcc), .FRAME(frame)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0]  vcc;
        logic [7:0]  red;
        logic [7:0]  green;
        logic        frame;
        logic [11:0] addr;
    } exp_t;

    exp_t sb_q[$];

    bit         m_run    = 1'b1;
    int         m_c      = 0;
    int         m_row    = 0;
    bit         m_bank   = 1'b0;
    bit         m_frame  = 1'b0;
    logic [7:0] m_data   = '0;
    logic [3:0] m_bright = '0;

    function automatic logic [11:0] m_addr();
        return m_run ? (BASE + 12'(m_bank ? 8 : 0) + 12'(m_row)) : BASE;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        bit   show, on;
        int   k;
        show = m_run && (m_c >= BLANK_CYC);
        k    = (m_c - BLANK_CYC) % 16;
        on   = !PWM_EN || (m_bright == 4'hF) || (k < int'(m_bright));
        e.vcc   = show ? 8'(1 << m_row) : 8'h00;
        e.red   = (show && on) ? ~m_data : 8'hFF;
        e.green = (show && on) ? m_data : 8'hFF;
        e.frame = m_frame;
        e.addr  = m_addr();
        return e;
    endfunction

    // Behavioural model: one expected output set per clock, pushed on the edge.
    always @(posedge clk or negedge rst_n) begin
        logic [11:0] a;
        if (!rst_n) begin
            m_run = 1'b1; m_c = 0; m_row = 0; m_bank = 1'b0;
            m_frame = 1'b0; m_data = '0; m_bright = '0;
            sb_q.delete();
        end else begin
            m_frame = 1'b0;
            if (!en) begin
                m_run = 1'b0; m_c = 0; m_row = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_c = 0; m_row = 0; m_bank = bank;
            end else begin
                m_c++;
                if (m_c == ROW_CYC) begin
                    m_c = 0;
                    m_row++;
                    if (m_row == ROWS) begin
                        m_row = 0; m_bank = bank; m_frame = 1'b1;
                    end
                end
                if (m_c == BLANK_CYC) begin
                    a        = m_addr();
                    m_data   = a[7:0];
                    m_bright = bright;
                end
            end
            sb_q.push_back(m_expect());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_vcc",   l_vcc,    e.vcc);
            check("sb_red",   l_red,    e.red);
            check("sb_green", l_green,  e.green);
            check("sb_frame", frame,    e.frame);
            check("sb_addr",  ram_addr, e.addr);
        end
    end

    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_vcc",   l_vcc,    8'h00);
        check("rst_red",   l_red,    8'hFF);
        check("rst_green", l_green,  8'hFF);
        check("rst_addr",  ram_addr, 12'hF00);
        check("rst_frame", frame,    1'b0);
        rst_n = 1'b1;

        // Scan order and blanking
        wait_to(10);
        check("r0_vcc", l_vcc, 8'h01);
        check("r0_addr", ram_addr, 12'hF00);
        wait_to(2*64 + 10);
        check("r2_vcc", l_vcc, 8'h04);
        check("r2_red", l_red, 8'hFD);
        check("r2_green", l_green, 8'h02);
        check("r2_addr", ram_addr, 12'hF02);
        for (int i = 0; i < BLANK_CYC; i++) begin
            wait_to(3*64 + i);
            check("blank_vcc", l_vcc, 8'h00);
            check("blank_red", l_red, 8'hFF);
            check("blank_green", l_green, 8'hFF);
        end
        wait_to(3*64 + 4);
        check("show_vcc", l_vcc, 8'h08);
        check("show_green", l_green, 8'h03);
        wait_to(7*64 + 5);
        check("r7_vcc", l_vcc, 8'h80);
        check("r7_addr", ram_addr, 12'hF07);
        wait_to(512);
        check("wrap_frame", frame, 1'b1);
        check("wrap_addr", ram_addr, 12'hF00);
        wait_to(513);
        check("wrap_frame_end", frame, 1'b0);

        // PWM
        wait_to(520);
        bright = 4'd4;
        wait_to(530);
        check("pwm_old_row", l_green, 8'h00);
        wait_to(576 + 4 + 2);
        check("pwm4_on", l_green, 8'h01);
        wait_to(576 + 4 + 5);
        check("pwm4_off", l_green, PWM_EN ? 8'hFF : 8'h01);
        wait_to(576 + 4 + 19);
        check("pwm4_wrap_on", l_green, 8'h01);
        bright = 4'd0;
        wait_to(610);
        check("pwm_midrow_hold", l_green, PWM_EN ? 8'hFF : 8'h01);
        wait_to(640 + 10);
        check("pwm0_off", l_green, PWM_EN ? 8'hFF : 8'h02);
        wait_to(660);
        bright = 4'hF;

        // Bank swap
        wait_to(704 + 5);
        bank = 1'b1;
        wait_to(704 + 20);
        check("bank_hold_addr", ram_addr, 12'hF03);
        check("bank_hold_green", l_green, 8'h03);
        wait_to(1023);
        check("pre_wrap_addr", ram_addr, 12'hF07);
        check("pre_wrap_frame", frame, 1'b0);
        wait_to(1024);
        check("bank_frame", frame, 1'b1);
        check("bank_addr", ram_addr, 12'hF08);
        wait_to(1025);
        check("bank_frame_end", frame, 1'b0);
        wait_to(1024 + 64 + 10);
        check("bank_r1_addr", ram_addr, 12'hF09);
        check("bank_r1_green", l_green, 8'h09);

        // Enable
        wait_to(1024 + 5*64 + 20);
        en = 1'b0;
        wait_to(1365);
        check("en_off_vcc", l_vcc, 8'h00);
        check("en_off_red", l_red, 8'hFF);
        check("en_off_green", l_green, 8'hFF);
        check("en_off_addr", ram_addr, 12'hF00);
        wait_to(1370);
        en = 1'b1;
        wait_to(1371);
        check("en_restart_addr", ram_addr, 12'hF08);
        check("en_restart_frame", frame, 1'b0);
        check("en_restart_vcc", l_vcc, 8'h00);
        bank = 1'b0;
        wait_to(1375);
        check("en_restart_show", l_vcc, 8'h01);
        check("en_restart_green", l_green, 8'h08);

        // EN fall coinciding with the row wrap
        wait_to(1371 + 511);
        en = 1'b0;
        wait_to(1883);
        check("en_wrap_frame", frame, 1'b0);
        check("en_wrap_addr", ram_addr, 12'hF00);
        wait_to(1885);
        en = 1'b1;

        // Async reset with the clock stopped
        wait_to(1886 + 128 + 30);
        check("pre_rst_vcc", l_vcc, 8'h04);
        clk_run = 1'b0;
        bank = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_vcc", l_vcc, 8'h00);
        check("arst_red", l_red, 8'hFF);
        check("arst_green", l_green, 8'hFF);
        check("arst_addr", ram_addr, 12'hF00);
        check("arst_frame", frame, 1'b0);
        #10 rst_n = 1'b1;
        #10 clk_run = 1'b1;
        wait_to(40);
        check("post_rst_addr", ram_addr, 12'hF00);
        check("post_rst_vcc", l_vcc, 8'h01);
        wait_to(64 + 5);
        check("post_rst_r1_addr", ram_addr, 12'hF01);
        check("post_rst_r1_vcc", l_vcc, 8'h02);
        wait_to(600);
        check("post_rst_bank1", ram_addr, 12'hF09);
        wait_to(610);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Parametrised row-scanning driver for bi-colour (red/green) LED matrices. It fetches one framebuffer word per row from synchronous RAM, blanks the matrix between rows to suppress ghosting, and drives one-hot row select plus active-low column data. It adds double-buffered frame banks, per-row PWM brightness, enable control and a frame-sync pulse. It sits between the CPU data RAM and the matrix pins.

## Interface
Parameters:
- ROWS, 8, matrix rows (≥2)
- COLS, 8, matrix columns per colour
- ADDR_W, 12, RAM address width
- FB_BASE, 12'hF00, framebuffer base address (bank 0)
- ROW_CYC, 4096, clock cycles per row period
- BLANK_CYC, 16, blanking cycles at start of each row (≥2, < ROW_CYC-1)
- PWM_BITS, 4, brightness resolution

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- EN  in  1  scan enable
- BANK  in  1  framebuffer bank select, sampled at frame start
- BRIGHT  in  PWM_BITS  brightness, sampled once per row
- RAM_Q  in  2*COLS  RAM read data; [2*COLS-1:COLS] red, [COLS-1:0] green; 1 = LED on
- RAM_ADDR  out  ADDR_W  RAM read address
- L_GREEN  out  COLS  green columns, active-low
- L_RED  out  COLS  red columns, active-low
- L_VCC  out  ROWS  row select, one-hot active-high
- FRAME  out  1  one-cycle frame-start pulse

## Operation
- All outputs registered. Reset values: L_VCC=0, L_GREEN/L_RED all ones, FRAME=0, RAM_ADDR=FB_BASE, row=0, cycle counter c=0, bank_q=0, data register 0.
- Row period: c counts 0..ROW_CYC-1, wraps; row increments at wrap, ROWS-1 → 0.
- RAM_ADDR = FB_BASE + bank_q*ROWS + row, modulo 2^ADDR_W; updated on the edge that starts c=0 and stable for the whole row period.
- BLANK (c = 0..BLANK_CYC-1): L_VCC=0, colours all ones. On the edge ending c=BLANK_CYC-1, RAM_Q and BRIGHT are captured. RAM read latency of 1 cycle is tolerated.
- SHOW (c = BLANK_CYC..ROW_CYC-1): L_VCC = 1<<row.
  - Colour outputs are ~data when PWM-on, all ones when PWM-off.
  - PWM: k = c-BLANK_CYC. On iff (k mod 2^PWM_BITS) < BRIGHT_q, or BRIGHT_q = all ones (always on).
- Frame boundary: on the row wrap ROWS-1 → 0, BANK is sampled into bank_q and FRAME is high for that first cycle (c=0, row 0).
- EN low: on the next edge, outputs go to reset values, row=0, c=0, FRAME=0. bank_q is held. When EN returns high, the scan restarts at row 0, c=0 with BANK sampled. No FRAME pulse is issued for this restart.
- RST_N low at any time, including mid-row, immediately forces the reset values without waiting for a clock edge.

## Timing
- Row period is exactly ROW_CYC cycles. Frame period is ROWS*ROW_CYC cycles.
- Data shown in a row equals RAM contents at RAM_ADDR one cycle before the capture edge. Changes to RAM during SHOW are not visible until that row's next period.
- BANK and BRIGHT changes mid-frame or mid-row have no effect until the next sample point.
- Simultaneous EN fall and row wrap: EN wins, FRAME stays 0.

## Configuration
- MATRIX_SCAN_PWM_EN defined: BRIGHT-based PWM gating as described.
- MATRIX_SCAN_PWM_EN undefined:
  - BRIGHT is ignored and the PWM counter is not built.
  - Colours equal ~data for the whole SHOW phase.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: ROWS=8, COLS=8, ROW_CYC=64, BLANK_CYC=4, PWM_BITS=4. The RAM model returns {addr[7:0], ~addr[7:0]} with 1-cycle latency.

1. Scan order:
   - Stimulus: release reset, EN=1, BRIGHT=15.
   - Response: RAM_ADDR steps 0xF00..0xF07 every 64 cycles then wraps; L_VCC steps 0x01..0x80, 0x01. In row 2 SHOW, L_RED=~8'h02 and L_GREEN=8'h02.
2. Blanking:
   - Stimulus: observe every row period.
   - Response: cycles c=0..3 give L_VCC=0 and L_RED=L_GREEN=8'hFF. Cycle c=4 gives valid row data.
3. PWM (macro defined):
   - BRIGHT=4: colours active for k mod 16 in 0..3 only.
   - BRIGHT=0: always 8'hFF.
   - BRIGHT=15: always active.
   - BRIGHT changed mid-row: takes effect only from the next row.
4. Bank swap:
   - Stimulus: set BANK=1 during row 3.
   - Response: addresses stay 0xF03..0xF07. FRAME is high for exactly one cycle at the wrap. The next frame reads 0xF08..0xF0F.
5. Enable:
   - Stimulus: EN=0 at row 5, c=20.
   - Response: the next cycle shows L_VCC=0, colours 8'hFF, RAM_ADDR=0xF00. After EN=1, row 0 restarts at c=0 with no FRAME pulse.
6. Async reset:
   - Stimulus: drop RST_N mid-SHOW with the clock stopped.
   - Response: outputs take reset values immediately. After release, the scan resumes at row 0 with bank 0.
